// File: rtl/fmult.sv
// Two-stage pipelined bfloat16 multiplier: round-to-nearest-even, subnormals flushed to zero.
// Stage 1 registers the operand class, sign, exponent sum and significand product; stage 2 registers the packed result.
module fmult (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] ap_return
);

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_e;

    // stage 1
    logic        sign_d, sign_q;
    cls_e        cls_d, cls_q;
    logic [9:0]  exp_sum_d, exp_sum_q;
    logic [15:0] prod_d, prod_q;

    // stage 2
    logic [15:0] ap_return_d, ap_return_q;

    logic a_zero, a_inf, a_nan;
    logic b_zero, b_inf, b_nan;

    always_comb begin
        a_zero = (a[14:7] == 8'h00);
        a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'h00);
        a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'h00);
        b_zero = (b[14:7] == 8'h00);
        b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'h00);
        b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'h00);

        sign_d = a[15] ^ b[15];

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            cls_d = CLS_NAN;
        end else if (a_inf || b_inf) begin
            cls_d = CLS_INF;
        end else if (a_zero || b_zero) begin
            cls_d = CLS_ZERO;
        end else begin
            cls_d = CLS_NORM;
        end

        // Modulo-1024 arithmetic; the register is read back as two's complement.
        exp_sum_d = {2'b00, a[14:7]} + {2'b00, b[14:7]} - 10'd127;
        prod_d    = {8'd0, 1'b1, a[6:0]} * {8'd0, 1'b1, b[6:0]};
    end

    logic signed [9:0] e_norm, e_rnd;
    logic [6:0]        frac;
    logic              guard, sticky, rnd_up;
    logic [7:0]        frac_inc;

    always_comb begin
        if (prod_q[15]) begin
            frac   = prod_q[14:8];
            guard  = prod_q[7];
            sticky = |prod_q[6:0];
            e_norm = $signed(exp_sum_q) + 10'sd1;
        end else begin
            frac   = prod_q[13:7];
            guard  = prod_q[6];
            sticky = |prod_q[5:0];
            e_norm = $signed(exp_sum_q);
        end

        rnd_up   = guard & (sticky | frac[0]);
        frac_inc = {1'b0, frac} + {7'd0, rnd_up};
        // A carry out leaves frac_inc[6:0] at zero, so only the exponent needs bumping.
        e_rnd    = frac_inc[7] ? (e_norm + 10'sd1) : e_norm;

        ap_return_d = 16'h0000;
        case (cls_q)
            CLS_NAN:  ap_return_d = 16'h7FC0;
            CLS_INF:  ap_return_d = {sign_q, 8'hFF, 7'h00};
            CLS_ZERO: ap_return_d = {sign_q, 15'h0000};
            default: begin
                if (e_rnd >= 10'sd255) begin
                    ap_return_d = {sign_q, 8'hFF, 7'h00};
                end else if (e_rnd <= 10'sd0) begin
                    ap_return_d = {sign_q, 15'h0000};
                end else begin
                    ap_return_d = {sign_q, e_rnd[7:0], frac_inc[6:0]};
                end
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            sign_q      <= 1'b0;
            cls_q       <= CLS_ZERO;
            exp_sum_q   <= 10'd0;
            prod_q      <= 16'd0;
            ap_return_q <= 16'h0000;
        end else begin
            sign_q      <= sign_d;
            cls_q       <= cls_d;
            exp_sum_q   <= exp_sum_d;
            prod_q      <= prod_d;
            ap_return_q <= ap_return_d;
        end
    end

    assign ap_return = ap_return_q;

endmodule

// File: tb/tb_fmult.sv
// Bench for fmult: directed vectors and a real-arithmetic reference model feed a scoreboard
// that is checked two edges after each operand pair is applied.
module tb_fmult;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic [15:0] ap_return;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    fmult dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .a         (a),
        .b         (b),
        .ap_return (ap_return)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got t=%0t required finish earlier", $time);
        $fatal(1);
    end

    // Independent reference: widen to double, multiply exactly, round the double back to bf16.
    // Valid only when operands and product stay in the normal bf16 range.
    function automatic logic [15:0] model_mul(input logic [15:0] x, input logic [15:0] y);
        real         rx, ry;
        logic [63:0] p;
        logic        inc;
        logic [8:0]  fr;
        int          e;
        rx  = $bitstoreal({x[15], 11'(x[14:7]) + 11'd896, x[6:0], 45'd0});
        ry  = $bitstoreal({y[15], 11'(y[14:7]) + 11'd896, y[6:0], 45'd0});
        p   = $realtobits(rx * ry);
        inc = p[44] & ((|p[43:0]) | p[45]);
        fr  = {2'b00, p[51:45]} + {8'd0, inc};
        e   = int'(p[62:52]) - 896 + (fr[7] ? 1 : 0);
        return {p[63], e[7:0], fr[6:0]};
    endfunction

    task automatic test_reset();
        #2;
        n_checks++;
        if (ap_return !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_initial: got %h expected 0000", ap_return);
        end
        a = 16'h3FC0; b = 16'h4010;
        @(posedge ap_clk); #1;
        @(posedge ap_clk); #1;
        n_checks++;
        if (ap_return !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_held: got %h expected 0000", ap_return);
        end
        ap_rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] va[4] = '{16'h3FC0, 16'h4300, 16'h5300, 16'h2300};
        logic [15:0] vb[4] = '{16'h4010, 16'h3C80, 16'h3C80, 16'h3C80};
        logic [15:0] ve[4] = '{16'h4058, 16'h4000, 16'h5000, 16'h2000};
        logic [15:0] exp_v;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                a = va[i]; b = vb[i];
                exp_q.push_back(ve[i]);
            end
            @(posedge ap_clk); #1;
            if (i >= 1) begin
                exp_v = exp_q.pop_front();
                n_checks++;
                if (ap_return !== exp_v) begin
                    n_fail++;
                    $display("FAIL back_to_back[%0d]: got %h expected %h", i - 1, ap_return, exp_v);
                end
            end
        end
    endtask

    task automatic test_rounding();
        logic [15:0] va[5] = '{16'h3F81, 16'h3FC0, 16'hBFC0, 16'hBF80, 16'h3F81};
        logic [15:0] vb[5] = '{16'h3F81, 16'h3F81, 16'h4010, 16'hBF80, 16'h3FC1};
        logic [15:0] ve[5] = '{16'h3F82, 16'h3FC2, 16'hC058, 16'h3F80, 16'h3FC3};
        logic [15:0] exp_v;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) begin
                a = va[i]; b = vb[i];
                exp_q.push_back(ve[i]);
            end
            @(posedge ap_clk); #1;
            if (i >= 1) begin
                exp_v = exp_q.pop_front();
                n_checks++;
                if (ap_return !== exp_v) begin
                    n_fail++;
                    $display("FAIL rounding[%0d]: a=%h b=%h got %h expected %h",
                             i - 1, va[i-1], vb[i-1], ap_return, exp_v);
                end
            end
        end
    endtask

    task automatic test_specials();
        logic [15:0] va[7] = '{16'h7F80, 16'h7FC1, 16'hFF80, 16'h8000, 16'h0001, 16'h0000, 16'h4000};
        logic [15:0] vb[7] = '{16'h0000, 16'h3F80, 16'h4000, 16'h4000, 16'h4000, 16'hFF80, 16'hFFC0};
        logic [15:0] ve[7] = '{16'h7FC0, 16'h7FC0, 16'hFF80, 16'h8000, 16'h0000, 16'h7FC0, 16'h7FC0};
        logic [15:0] exp_v;
        for (int i = 0; i < 8; i++) begin
            if (i < 7) begin
                a = va[i]; b = vb[i];
                exp_q.push_back(ve[i]);
            end
            @(posedge ap_clk); #1;
            if (i >= 1) begin
                exp_v = exp_q.pop_front();
                n_checks++;
                if (ap_return !== exp_v) begin
                    n_fail++;
                    $display("FAIL specials[%0d]: a=%h b=%h got %h expected %h",
                             i - 1, va[i-1], vb[i-1], ap_return, exp_v);
                end
            end
        end
    endtask

    task automatic test_range();
        logic [15:0] va[5] = '{16'h7F00, 16'h0080, 16'h7F7F, 16'hFF00, 16'h0100};
        logic [15:0] vb[5] = '{16'h4000, 16'h3F00, 16'h3F80, 16'h4000, 16'h3F00};
        logic [15:0] ve[5] = '{16'h7F80, 16'h0000, 16'h7F7F, 16'hFF80, 16'h0080};
        logic [15:0] exp_v;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) begin
                a = va[i]; b = vb[i];
                exp_q.push_back(ve[i]);
            end
            @(posedge ap_clk); #1;
            if (i >= 1) begin
                exp_v = exp_q.pop_front();
                n_checks++;
                if (ap_return !== exp_v) begin
                    n_fail++;
                    $display("FAIL range[%0d]: a=%h b=%h got %h expected %h",
                             i - 1, va[i-1], vb[i-1], ap_return, exp_v);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] ra, rb, exp_v;
        for (int i = 0; i < 41; i++) begin
            if (i < 40) begin
                ra = {1'($urandom_range(1, 0)), 8'($urandom_range(160, 90)), 7'($urandom_range(127, 0))};
                rb = {1'($urandom_range(1, 0)), 8'($urandom_range(160, 90)), 7'($urandom_range(127, 0))};
                a = ra; b = rb;
                exp_q.push_back(model_mul(ra, rb));
            end
            @(posedge ap_clk); #1;
            if (i >= 1) begin
                exp_v = exp_q.pop_front();
                n_checks++;
                if (ap_return !== exp_v) begin
                    n_fail++;
                    $display("FAIL random[%0d]: got %h expected %h", i - 1, ap_return, exp_v);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        a = 16'h4300; b = 16'h3C80;
        @(posedge ap_clk); #1;
        a = 16'h3FC0; b = 16'h4010;
        @(posedge ap_clk); #1;
        n_checks++;
        if (ap_return !== 16'h4000) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got %h expected 4000", ap_return);
        end
        #3;
        ap_rst_n = 1'b0;
        #1;
        n_checks++;
        if (ap_return !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h expected 0000", ap_return);
        end
        exp_q.delete();
        @(posedge ap_clk); #1;
        n_checks++;
        if (ap_return !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid_held: got %h expected 0000", ap_return);
        end
        ap_rst_n = 1'b1;
        a = 16'hBF80; b = 16'hBF80;
        exp_q.push_back(16'h3F80);
        @(posedge ap_clk); #1;
        a = 16'h0000; b = 16'h0000;
        n_checks++;
        if (ap_return !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid_no_stale: got %h expected 0000", ap_return);
        end
        @(posedge ap_clk); #1;
        n_checks++;
        if (ap_return !== exp_q[0]) begin
            n_fail++;
            $display("FAIL reset_mid_first: got %h expected %h", ap_return, exp_q[0]);
        end
        void'(exp_q.pop_front());
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_rounding();
        test_specials();
        test_range();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
